// File: rtl/window_recycler_pkg.sv
// Shared types and helpers for the window recycler and its window shift register.
package window_recycler_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DRAIN  = 2'd2
  } rec_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_recycler_shift_reg.sv
// FILTER_LEN-deep vector shift register; newest vector enters the top slot, slot 0 is oldest.
module window_shift_reg #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 104
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [DEPTH*WIDTH-1:0] dout_o
);

  logic [DEPTH*WIDTH-1:0] taps;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      taps <= {din_i, taps[DEPTH*WIDTH-1:WIDTH]};
    end
  end

  assign dout_o = taps;

endmodule

// File: rtl/window_recycler.sv
// Buffers one frame of feature vectors and replays it NUM_FILTERS times as
// FILTER_LEN-wide sliding windows with ready/valid flow control on both sides.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_LOAD   | accepting vectors into the frame buffer
// ST_REPLAY | input stalled; emitting sliding windows, one pass per filter
// ST_DRAIN  | frame overran its length; discarding beats until last_i
module window_recycler
  import window_recycler_pkg::*;
#(
  parameter int BW          = 8,
  parameter int VECTOR_LEN  = 13,
  parameter int FRAME_LEN   = 50,
  parameter int FILTER_LEN  = 3,
  parameter int NUM_FILTERS = 8,
  localparam int VECTOR_BW  = VECTOR_LEN * BW,
  localparam int IDX_W      = clog2_min1(NUM_FILTERS)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [VECTOR_BW-1:0]            data_i,
  input  logic                            valid_i,
  input  logic                            last_i,
  output logic                            ready_o,
  output logic [FILTER_LEN*VECTOR_BW-1:0] data_o,
  output logic                            valid_o,
  output logic                            last_o,
  input  logic                            ready_i,
  output logic [IDX_W-1:0]                filter_idx_o,
  output logic                            err_o
);

  localparam int AW = clog2_min1(FRAME_LEN);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(FRAME_LEN - 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(FILTER_LEN);
  localparam logic [FW-1:0]    FILL_PRE  = FW'(FILTER_LEN - 1);
  localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(NUM_FILTERS - 1);

  rec_state_e state, state_nxt;

  logic [VECTOR_BW-1:0] frame_buf [FRAME_LEN];
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        rd_addr;
  logic [FW-1:0]        fill;
  logic [IDX_W-1:0]     pass_cnt;
  logic                 replay_done;
  logic                 advance;
  logic                 shift_en;
  logic                 taken;
  logic                 err_nxt;
  logic                 wr_en;

  assign taken = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_LOAD;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      err_o <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    advance   = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_LOAD: begin
        ready_o = 1'b1;
        wr_en   = valid_i;
        if (valid_i) begin
          if (last_i) begin
            if (wr_addr == ADDR_LAST) state_nxt = ST_REPLAY;
            else                      err_nxt   = 1'b1;
          end else if (wr_addr == ADDR_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        ready_o = 1'b1;
        if (valid_i && last_i) state_nxt = ST_LOAD;
      end
      ST_REPLAY: begin
        advance  = !valid_o || ready_i;
        shift_en = advance && !replay_done;
        if (replay_done && taken) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      frame_buf[wr_addr] <= data_i;
    end
  end

  // Short, overlong and good frames all restart the write pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      if (last_i || wr_addr == ADDR_LAST) wr_addr <= '0;
      else                                wr_addr <= wr_addr + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_addr      <= '0;
      fill         <= '0;
      pass_cnt     <= '0;
      replay_done  <= 1'b0;
      valid_o      <= 1'b0;
      last_o       <= 1'b0;
      filter_idx_o <= '0;
    end else if (state == ST_REPLAY) begin
      if (replay_done) begin
        if (taken) begin
          valid_o     <= 1'b0;
          last_o      <= 1'b0;
          replay_done <= 1'b0;
          pass_cnt    <= '0;
        end
      end else if (advance) begin
        fill    <= (fill == FILL_FULL) ? fill : fill + FW'(1);
        valid_o <= (fill >= FILL_PRE);
        last_o  <= (rd_addr == ADDR_LAST);
        // Pass index is latched with each window so it cannot move under a valid beat.
        if (fill >= FILL_PRE) filter_idx_o <= pass_cnt;
        if (rd_addr == ADDR_LAST) begin
          rd_addr <= '0;
          fill    <= '0;
          if (pass_cnt == PASS_LAST) replay_done <= 1'b1;
          else                       pass_cnt    <= pass_cnt + IDX_W'(1);
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
      end
    end
  end

  window_shift_reg #(
    .DEPTH (FILTER_LEN),
    .WIDTH (VECTOR_BW)
  ) u_window (
    .clk_i  (clk_i),
    .en_i   (shift_en),
    .din_i  (frame_buf[rd_addr]),
    .dout_o (data_o)
  );

endmodule

// File: tb/tb_window_recycler.sv
// Scoreboard bench: drives one shared input stream into a 3-wide/2-pass and a
// 5-wide/1-pass recycler and checks every window popped against queued models.
module tb_window_recycler;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  idx;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_i = 1'b1;

  logic        ready_o, valid_o, last_o, err_o;
  logic [23:0] data_o;
  logic [0:0]  filter_idx_o;

  logic        ready5_o, valid5_o, last5_o, err5_o;
  logic [39:0] data5_o;
  logic [0:0]  filter_idx5_o;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_beats3 = 0;
  int   n_beats5 = 0;
  bit   rand_ready = 1'b0;
  exp_t q3[$];
  exp_t q5[$];

  bit          stall3 = 0, stall5 = 0;
  logic [63:0] hd3, hd5;
  logic        hl3, hl5;
  logic [7:0]  hi3, hi5;

  window_recycler #(
    .BW(8), .VECTOR_LEN(1), .FRAME_LEN(8), .FILTER_LEN(3), .NUM_FILTERS(2)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .last_o(last_o), .ready_i(ready_i), .filter_idx_o(filter_idx_o), .err_o(err_o)
  );

  window_recycler #(
    .BW(8), .VECTOR_LEN(1), .FRAME_LEN(8), .FILTER_LEN(5), .NUM_FILTERS(1)
  ) dut5 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready5_o), .data_o(data5_o), .valid_o(valid5_o),
    .last_o(last5_o), .ready_i(ready_i), .filter_idx_o(filter_idx5_o), .err_o(err5_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_model(input int base, input int flen, input int nfilt, input bit wide);
    exp_t e;
    for (int p = 0; p < nfilt; p++) begin
      for (int s = 0; s <= 8 - flen; s++) begin
        e.data = '0;
        for (int k = 0; k < flen; k++) e.data[k*8 +: 8] = 8'(base + s + k);
        e.last = (s == 8 - flen);
        e.idx  = 8'(p);
        if (wide) q5.push_back(e);
        else      q3.push_back(e);
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, output logic e3, output logic e5);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(ready_o && ready5_o) && n < 300);
    if (n >= 300) check("ready_timeout", 64'(ready_o & ready5_o), 64'd1);
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    e3      = err_o;
    e5      = err5_o;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int nbeats, input int lastpos, input int errpos);
    logic e3, e5;
    for (int i = 1; i <= nbeats; i++) begin
      send_beat(8'(base + i - 1), (i == lastpos), e3, e5);
      check($sformatf("err3_b%0d", i), 64'(e3), 64'(i == errpos));
      check($sformatf("err5_b%0d", i), 64'(e5), 64'(i == errpos));
    end
  endtask

  task automatic good_frame(input int base);
    push_model(base, 3, 2, 1'b0);
    push_model(base, 5, 1, 1'b1);
    send_frame(base, 8, 8, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q3.size() == 0 && q5.size() == 0 && ready_o && ready5_o) && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_q3", 64'(q3.size()), 64'd0);
    check("idle_q5", 64'(q5.size()), 64'd0);
    check("idle_ready3", 64'(ready_o), 64'd1);
    check("idle_ready5", 64'(ready5_o), 64'd1);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_n_i) begin
      stall3 = 0;
    end else begin
      if (stall3) begin
        check("hold3_valid", 64'(valid_o), 64'd1);
        check("hold3_data", 64'(data_o), hd3);
        check("hold3_last", 64'(last_o), 64'(hl3));
        check("hold3_idx", 64'(filter_idx_o), 64'(hi3));
      end
      if (valid_o && ready_i) begin
        n_beats3++;
        if (q3.size() == 0) check("dut3_spurious_valid", 64'(valid_o), 64'd0);
        else begin
          e = q3.pop_front();
          check("dut3_data", 64'(data_o), e.data);
          check("dut3_last", 64'(last_o), 64'(e.last));
          check("dut3_idx", 64'(filter_idx_o), 64'(e.idx));
        end
      end
      stall3 = valid_o && !ready_i;
      hd3 = 64'(data_o); hl3 = last_o; hi3 = 8'(filter_idx_o);
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_n_i) begin
      stall5 = 0;
    end else begin
      if (stall5) begin
        check("hold5_valid", 64'(valid5_o), 64'd1);
        check("hold5_data", 64'(data5_o), hd5);
        check("hold5_last", 64'(last5_o), 64'(hl5));
        check("hold5_idx", 64'(filter_idx5_o), 64'(hi5));
      end
      if (valid5_o && ready_i) begin
        n_beats5++;
        if (q5.size() == 0) check("dut5_spurious_valid", 64'(valid5_o), 64'd0);
        else begin
          e = q5.pop_front();
          check("dut5_data", 64'(data5_o), e.data);
          check("dut5_last", 64'(last5_o), 64'(e.last));
          check("dut5_idx", 64'(filter_idx5_o), 64'(e.idx));
        end
      end
      stall5 = valid5_o && !ready_i;
      hd5 = 64'(data5_o); hl5 = last5_o; hi5 = 8'(filter_idx5_o);
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int n;
    #3 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_idx", 64'(filter_idx_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_valid5", 64'(valid5_o), 64'd0);
    rst_n_i = 1'b1;

    // Clean frame, ready_i held high.
    n_beats3 = 0;
    n_beats5 = 0;
    good_frame(1);
    wait_idle();
    check("s1_beats3", 64'(n_beats3), 64'd12);
    check("s1_beats5", 64'(n_beats5), 64'd4);

    // Same frame under random backpressure.
    rand_ready = 1'b1;
    good_frame(1);
    wait_idle();
    rand_ready = 1'b0;

    // Short frame, then a good one.
    send_frame(40, 5, 5, 5);
    wait_idle();
    good_frame(1);
    wait_idle();

    // Overlong frame: error on beat 8, beats 9-10 drained.
    send_frame(50, 10, 10, 8);
    wait_idle();
    good_frame(11);
    wait_idle();

    // Reset in the middle of pass 0.
    push_model(21, 3, 2, 1'b0);
    push_model(21, 5, 1, 1'b1);
    send_frame(21, 8, 8, 0);
    n = 0;
    n_beats3 = 0;
    while (n_beats3 < 2 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("s5_reached_mid", 64'(n_beats3 >= 2), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("s5_async_valid3", 64'(valid_o), 64'd0);
    check("s5_async_valid5", 64'(valid5_o), 64'd0);
    q3.delete();
    q5.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("s5_ready3", 64'(ready_o), 64'd1);
    check("s5_ready5", 64'(ready5_o), 64'd1);
    check("s5_valid3_after", 64'(valid_o), 64'd0);
    good_frame(31);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
